// File: rtl/var_packer_pkg.sv
// Shared state type and width/mask helpers for the variable-length bit packer.
package var_packer_pkg;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

  localparam int MASK_W = 256;

  function automatic int last_bits_width(int bus_width);
    return $clog2(bus_width + 1);
  endfunction

  function automatic int num_bits_width(int max_in_width);
    return $clog2(max_in_width + 1);
  endfunction

  // Callers cast the result down to their own codeword width.
  function automatic logic [MASK_W-1:0] low_mask(int n);
    logic [MASK_W-1:0] m;
    if (n >= MASK_W) m = '1;
    else m = (MASK_W'(1) << n) - MASK_W'(1);
    return m;
  endfunction

endpackage

// File: rtl/var_packer_out_reg.sv
// Single-entry valid/ready output register for packed words; contents hold while stalled.
module var_packer_out_reg #(
  parameter int DATA_W = 64,
  parameter int BITS_W = 7
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              load,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  input  logic [BITS_W-1:0] load_last_bits,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data,
  output logic [BITS_W-1:0] out_last_bits
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_data      <= '0;
      out_last_bits <= '0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_last      <= load_last;
      out_data      <= load_data;
      out_last_bits <= load_last_bits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/var_bit_packer.sv
// Packs variable-length codewords MSB-first into BUS_WIDTH-bit words with a zero-padded last flush.
// Optional stat_bits/stat_words counters are built when VAR_BIT_PACKER_COUNT_EN is defined.
module var_bit_packer
  import var_packer_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int MAX_IN_WIDTH = 32,
`ifdef VAR_BIT_PACKER_COUNT_EN
  parameter int CNT_W        = 32,
`endif
  localparam int NB_W        = num_bits_width(MAX_IN_WIDTH),
  localparam int LB_W        = last_bits_width(BUS_WIDTH)
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MAX_IN_WIDTH-1:0] in_data,
  input  logic [NB_W-1:0]         in_num_bits,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BUS_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic [LB_W-1:0]         out_last_bits
`ifdef VAR_BIT_PACKER_COUNT_EN
  ,
  output logic [CNT_W-1:0]        stat_bits,
  output logic [CNT_W-1:0]        stat_words
`endif
);

  localparam int ACC_W  = BUS_WIDTH + MAX_IN_WIDTH;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] BUS_FILL = FILL_W'(BUS_WIDTH);
  localparam logic [FILL_W-1:0] ACC_FILL = FILL_W'(ACC_W);

  state_t                  state;
  logic [ACC_W-1:0]        acc, acc_base, ins;
  logic [FILL_W-1:0]       fill, fill_base, n_fill;
  logic [NB_W-1:0]         n_sat;
  logic [MAX_IN_WIDTH-1:0] data_masked;
  logic                    word_avail, can_load, load_now, load_last, accept;
  logic [LB_W-1:0]         load_last_bits;

  // A load and an accept in the same cycle compose: shift out first, then append below.
  always_comb begin
    n_sat = (in_num_bits > NB_W'(MAX_IN_WIDTH)) ? NB_W'(MAX_IN_WIDTH) : in_num_bits;
    n_fill = FILL_W'(n_sat);
    data_masked = in_data & MAX_IN_WIDTH'(low_mask(int'(n_sat)));
    word_avail = 1'b0;
    case (state)
      RUN:     word_avail = (fill >= BUS_FILL);
      FLUSH:   word_avail = 1'b1;
      default: word_avail = 1'b0;
    endcase
    load_now = word_avail && can_load;
    load_last = (state == FLUSH) && (fill <= BUS_FILL);
    load_last_bits = load_last ? LB_W'(fill) : LB_W'(BUS_WIDTH);
    in_ready = (state == RUN) && ((fill < BUS_FILL) || load_now);
    accept = in_valid && in_ready;
    acc_base = load_now ? (acc << BUS_WIDTH) : acc;
    fill_base = load_now ? (fill - BUS_FILL) : fill;
    ins = ACC_W'(data_masked) << (ACC_FILL - fill_base - n_fill);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= RUN;
      acc   <= '0;
      fill  <= '0;
    end else begin
      case (state)
        RUN: begin
          acc  <= accept ? (acc_base | ins) : acc_base;
          fill <= accept ? (fill_base + n_fill) : fill_base;
          if (accept && in_last) state <= FLUSH;
        end
        FLUSH: begin
          if (load_now) begin
            if (load_last) begin
              acc   <= '0;
              fill  <= '0;
              state <= DRAIN;
            end else begin
              acc  <= acc_base;
              fill <= fill_base;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  var_packer_out_reg #(
    .DATA_W(BUS_WIDTH),
    .BITS_W(LB_W)
  ) u_out_reg (
    .clk            (clk),
    .aresetn        (aresetn),
    .load           (load_now),
    .load_last      (load_last),
    .load_data      (acc[ACC_W-1 -: BUS_WIDTH]),
    .load_last_bits (load_last_bits),
    .out_ready      (out_ready),
    .can_load       (can_load),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_data       (out_data),
    .out_last_bits  (out_last_bits)
  );

`ifdef VAR_BIT_PACKER_COUNT_EN
  // Padding never counts toward stat_bits; only accepted payload does.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_bits  <= '0;
      stat_words <= '0;
    end else begin
      if (accept) stat_bits <= stat_bits + CNT_W'(n_sat);
      if (out_valid && out_ready) stat_words <= stat_words + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_var_bit_packer.sv
// Bench for var_bit_packer: an 8/8 and a 32/16 instance checked against a bit-level
// scoreboard of accepted payload bits, popped one output word at a time.
module tb_var_bit_packer;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_last8;
  logic [7:0]  in_data8, out_data8;
  logic [3:0]  in_nb8, out_lb8;
  logic        in_valid32, in_ready32, in_last32, out_valid32, out_ready32, out_last32;
  logic [15:0] in_data32;
  logic [4:0]  in_nb32;
  logic [31:0] out_data32;
  logic [5:0]  out_lb32;
`ifdef VAR_BIT_PACKER_COUNT_EN
  logic [31:0] stat_bits8, stat_words8, stat_bits32, stat_words32;
`endif

  var_bit_packer #(.BUS_WIDTH(8), .MAX_IN_WIDTH(8)) u_dut8 (
`ifdef VAR_BIT_PACKER_COUNT_EN
    .stat_bits(stat_bits8), .stat_words(stat_words8),
`endif
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_num_bits(in_nb8), .in_last(in_last8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_last(out_last8), .out_last_bits(out_lb8)
  );

  var_bit_packer #(.BUS_WIDTH(32), .MAX_IN_WIDTH(16)) u_dut32 (
`ifdef VAR_BIT_PACKER_COUNT_EN
    .stat_bits(stat_bits32), .stat_words(stat_words32),
`endif
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_num_bits(in_nb32), .in_last(in_last32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_last(out_last32), .out_last_bits(out_lb32)
  );

  int checks = 0;
  int failures = 0;
  bit exp_q[2][$];
  bit last_seen[2];
  bit done[2];
  int words[2];
  int accepts[2];
  int bits_total[2];
  int ready_mode[2];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      last_seen[d] = 0;
      done[d] = 0;
      words[d] = 0;
      accepts[d] = 0;
      bits_total[d] = 0;
    end
  endtask

  task automatic pushCode(int d, logic [15:0] data, int n, logic last, int maxw);
    int neff;
    neff = (n > maxw) ? maxw : n;
    for (int i = neff - 1; i >= 0; i--) exp_q[d].push_back(data[i]);
    if (last) last_seen[d] = 1;
    accepts[d]++;
    bits_total[d] += neff;
  endtask

  // A word is final once the stream's last codeword is in and at most one bus of bits remains.
  task automatic popWord(int d, logic [63:0] data, logic last, int bits, int bus);
    int rem;
    logic exp_last;
    int exp_bits;
    logic [63:0] exp_data;
    rem = exp_q[d].size();
    exp_last = last_seen[d] && (rem <= bus);
    exp_bits = exp_last ? rem : bus;
    exp_data = '0;
    checkOutput("sb_underflow", 64'((rem >= bus) || exp_last), 64'd1);
    for (int i = 0; i < bus; i++) begin
      if (i < exp_bits && exp_q[d].size() > 0) exp_data[bus-1-i] = exp_q[d].pop_front();
    end
    checkOutput(d == 0 ? "w8_data" : "w32_data", data, exp_data);
    checkOutput(d == 0 ? "w8_last" : "w32_last", 64'(last), 64'(exp_last));
    checkOutput(d == 0 ? "w8_bits" : "w32_bits", 64'(bits), 64'(exp_bits));
    words[d]++;
    if (exp_last) last_seen[d] = 0;
    if (last) done[d] = 1;
  endtask

  always @(negedge clk) begin
    if (aresetn) begin
      if (in_valid8 && in_ready8) pushCode(0, 16'(in_data8), int'(in_nb8), in_last8, 8);
      if (out_valid8 && out_ready8) popWord(0, 64'(out_data8), out_last8, int'(out_lb8), 8);
      if (in_valid32 && in_ready32) pushCode(1, in_data32, int'(in_nb32), in_last32, 16);
      if (out_valid32 && out_ready32) popWord(1, 64'(out_data32), out_last32, int'(out_lb32), 32);
    end
  end

  function automatic logic readyFor(int mode);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 2) != 0);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    out_ready8 = 1'b1;
    out_ready32 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready8 = readyFor(ready_mode[0]);
      out_ready32 = readyFor(ready_mode[1]);
    end
  end

  task automatic applyStimulus(int d, logic [15:0] data, int n, logic last);
    bit ok;
    ok = 0;
    if (d == 0) begin
      in_valid8 = 1'b1; in_data8 = data[7:0]; in_nb8 = 4'(n); in_last8 = last;
    end else begin
      in_valid32 = 1'b1; in_data32 = data; in_nb32 = 5'(n); in_last32 = last;
    end
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if ((d == 0) ? in_ready8 : in_ready32) begin
        ok = 1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int d, int k);
    if (d == 0) in_valid8 = 1'b0;
    else in_valid32 = 1'b0;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(int d);
    bit ok;
    ok = 0;
    for (int g = 0; g < 4000; g++) begin
      @(posedge clk);
      if (done[d]) begin
        ok = 1;
        break;
      end
    end
    #1;
    checkOutput("stream_done", 64'(ok), 64'd1);
    checkOutput("sb_empty", 64'(exp_q[d].size()), 64'd0);
    done[d] = 0;
  endtask

  task automatic runStream(int d, int ncodes);
    int n;
    logic last;
    for (int i = 0; i < ncodes; i++) begin
      last = (i == ncodes - 1);
      if (d == 1) n = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      else n = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      if (last && n == 0) n = 1;
      applyStimulus(d, 16'($urandom), n, last);
      if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
    end
    idle(d, 1);
    waitDone(d);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0, t0;
    in_valid8 = 0; in_data8 = 0; in_nb8 = 0; in_last8 = 0;
    in_valid32 = 0; in_data32 = 0; in_nb32 = 0; in_last32 = 0;
    ready_mode[0] = 0;
    ready_mode[1] = 0;
    clearModel();
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid8), 64'd0);
    checkOutput("rst_out_last", 64'(out_last8), 64'd0);
    checkOutput("rst_out_data", 64'(out_data8), 64'd0);
    checkOutput("rst_out_last_bits", 64'(out_lb8), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready8), 64'd1);
    checkOutput("rst_out_valid32", 64'(out_valid32), 64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    idle(0, 1);

    $display("[TB] five 6-bit codewords");
    w0 = words[0];
    for (int i = 0; i < 5; i++) applyStimulus(0, 16'h33, 6, i == 4);
    idle(0, 1);
    waitDone(0);
    checkOutput("t1_words", 64'(words[0] - w0), 64'd4);

    $display("[TB] exact fill on last codeword");
    w0 = words[0];
    for (int i = 0; i < 4; i++) applyStimulus(0, 16'h000A, 4, i == 3);
    idle(0, 1);
    waitDone(0);
    checkOutput("t2_words", 64'(words[0] - w0), 64'd2);

    $display("[TB] empty last codeword");
    w0 = words[0];
    applyStimulus(0, 16'h00FF, 0, 1'b1);
    idle(0, 1);
    waitDone(0);
    checkOutput("t3_words", 64'(words[0] - w0), 64'd1);

    $display("[TB] oversize num_bits saturates");
    w0 = words[0];
    applyStimulus(0, 16'hFFA5, 12, 1'b0);
    applyStimulus(0, 16'h000F, 4, 1'b1);
    idle(0, 1);
    waitDone(0);
    checkOutput("sat_words", 64'(words[0] - w0), 64'd2);

    $display("[TB] output stalled for 10 cycles");
    ready_mode[0] = 2;
    idle(0, 2);
    w0 = accepts[0];
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(0, 16'(8'h11 * (i + 1)), 8, i == 5);
        idle(0, 1);
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready", 64'(in_ready8), 64'd0);
        checkOutput("bp_accepts", 64'(accepts[0] - w0), 64'd2);
        checkOutput("bp_out_valid", 64'(out_valid8), 64'd1);
        ready_mode[0] = 0;
      end
    join
    waitDone(0);

    $display("[TB] reset mid-stream");
    applyStimulus(0, 16'h0016, 5, 1'b0);
    idle(0, 1);
    #2;
    aresetn = 1'b0;
    clearModel();
    @(negedge clk);
    checkOutput("mid_rst_out_valid", 64'(out_valid8), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    idle(0, 1);
    applyStimulus(0, 16'h005A, 8, 1'b0);
    applyStimulus(0, 16'h00C3, 8, 1'b1);
    idle(0, 1);
    waitDone(0);
    checkOutput("post_rst_words", 64'(words[0]), 64'd2);

    $display("[TB] 32-bit bus throughput");
    ready_mode[1] = 0;
    idle(1, 2);
    t0 = cyc;
    for (int i = 0; i < 40; i++) applyStimulus(1, 16'($urandom), $urandom_range(1, 16), i == 39);
    checkOutput("throughput_cycles", 64'(cyc - t0), 64'd40);
    idle(1, 1);
    waitDone(1);

    $display("[TB] random streams with bubbles");
    ready_mode[1] = 1;
    for (int s = 0; s < 3; s++) runStream(1, 50);
    ready_mode[0] = 1;
    runStream(0, 40);
    ready_mode[0] = 0;
    ready_mode[1] = 0;
    idle(0, 2);

`ifdef VAR_BIT_PACKER_COUNT_EN
    checkOutput("stat_words8", 64'(stat_words8), 64'(words[0]));
    checkOutput("stat_bits8", 64'(stat_bits8), 64'(bits_total[0]));
    checkOutput("stat_words32", 64'(stat_words32), 64'(words[1]));
    checkOutput("stat_bits32", 64'(stat_bits32), 64'(bits_total[1]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/var_bit_packer.md
Name: var_bit_packer

Overview:
- Packs a stream of variable-length codewords (1..MAX_IN_WIDTH valid bits each) MSB-first into BUS_WIDTH-bit output words.
- Successor to the fixed-bus packer: parametrised widths, full valid/ready backpressure on both sides, and a last-flush with zero padding.
- Reports the valid bit count of the final word.
- Sits between the encoder codeword stage and the output AXI-stream/DMA.

Parameters:
- BUS_WIDTH, 64: output word width in bits; must be >= 8.
- MAX_IN_WIDTH, 32: maximum codeword width; must be <= BUS_WIDTH.
- NB_W, $clog2(MAX_IN_WIDTH+1): width of in_num_bits (localparam, derived).
- CNT_W, 32: width of the total-bit counter (optional feature only).

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- in_valid  in  1  codeword valid
- in_ready  out  1  codeword accepted when in_valid && in_ready
- in_data  in  MAX_IN_WIDTH  codeword, right-aligned; bits above in_num_bits ignored
- in_num_bits  in  NB_W  valid bit count, 0..MAX_IN_WIDTH
- in_last  in  1  final codeword of the stream
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  BUS_WIDTH  packed word; first-received bit at MSB
- out_last  out  1  final word of the stream
- out_last_bits  out  $clog2(BUS_WIDTH+1)  valid bits in out_data; BUS_WIDTH except on a padded final word

Behaviour:
- Reset (asynchronous, aresetn=0):
  - out_valid=0, out_last=0, out_data=0, out_last_bits=0.
  - Accumulator and fill cleared; state=RUN.
  - Any partial data is discarded, including when reset is asserted mid-stream.
- Accumulator:
  - acc is BUS_WIDTH+MAX_IN_WIDTH bits, MSB-aligned; fill counts occupied bits.
  - On accept, the masked in_data[n-1:0] is placed directly below the current fill and fill += n.
  - in_num_bits > MAX_IN_WIDTH saturates to MAX_IN_WIDTH.
  - in_num_bits = 0 is accepted and adds no bits (in_last still honoured).
- Output register (1 stage):
  - A load occurs when a word is available and (!out_valid || out_ready).
  - On load, the top BUS_WIDTH bits of acc go to out_data, acc shifts left by BUS_WIDTH, and fill -= BUS_WIDTH.
  - out_data/out_last/out_last_bits are held stable while out_valid && !out_ready.
- States:
  - RUN:
    - Word available iff fill >= BUS_WIDTH.
    - in_ready = (fill < BUS_WIDTH) || load_now. This is combinational from out_ready and gives sustained 1 codeword/cycle when out_ready=1.
    - A load and an accept in the same cycle are both applied: fill' = fill - BUS_WIDTH + n.
    - Accepting in_last moves to FLUSH.
  - FLUSH:
    - in_ready=0.
    - While fill > BUS_WIDTH, load full words with out_last=0.
    - When fill <= BUS_WIDTH, load the final word: low bits zero-padded, out_last=1, out_last_bits=fill.
    - If fill==0 on FLUSH entry, emit one all-zero word with out_last=1 and out_last_bits=0.
    - Then go to DRAIN.
  - DRAIN:
    - in_ready=0.
    - On the final word's handshake, clear fill and go to RUN.
- Latency: first output word out_valid asserts 1 cycle after the accepting edge that brings fill >= BUS_WIDTH.
- Ordering: bit order is preserved exactly; no bits are dropped or duplicated under any backpressure pattern.

Optional Feature:
- Macro: VAR_BIT_PACKER_COUNT_EN.
- When defined:
  - Adds output stat_bits[CNT_W-1:0], the total payload bits accepted since reset (excluding padding).
  - Adds output stat_words[CNT_W-1:0], the output handshakes since reset.
  - Both counters wrap modulo 2^CNT_W and clear on reset only.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package var_packer_pkg holds:
  - State enum {RUN, FLUSH, DRAIN}.
  - Width helper functions (clog2 of BUS_WIDTH+1 and MAX_IN_WIDTH+1).
  - Mask-generation function for n valid bits.
- One natural sub-module: var_packer_out_reg, a single-entry valid/ready output register holding data/last/last_bits.

Test Plan:
- BUS=8, MAX_IN=8, out_ready=1: 5× {data=6'b110011, n=6}, last on 5th -> words 0xCF, 0x3C, 0xF3, 0xCC; out_last only on 0xCC; out_last_bits 8, 8, 8, 6.
- BUS=8: 4× n=4 data 0xA, last on 4th -> 0xAA, 0xAA; second word has out_last=1 and out_last_bits=8; no extra padded word.
- BUS=8: single codeword n=0 with in_last on an empty packer -> one word 0x00, out_last=1, out_last_bits=0.
- BUS=8, out_ready=0 for 10 cycles with continuous 8-bit input -> in_ready drops once fill >= 8; out_data held stable; after release all bytes arrive in order with no loss.
- BUS=32, MAX_IN=16, random n 0..16, random valid/ready bubbles -> concatenated output bits equal the reference model bit string; throughput is 1 codeword/cycle when both sides are always ready.
- Assert aresetn=0 mid-stream with fill=5 -> next cycle out_valid=0, in_ready=1; the following stream's output contains no residual bits.
